// File: rtl/uart_tx_serializer.sv
// Byte-oriented UART transmitter: small TX FIFO feeding a START/DATA/STOP serializer.
// Frame timing (baud, data bits, stop bits) is latched when a byte is popped.
module uart_tx_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CNT_W-1:0]              ctrl_baud_clks,
    input  logic [3:0]                    ctrl_bits,
    input  logic [1:0]                    ctrl_stops,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [CNT_W-1:0]   last_cnt_reg, last_cnt_next;
    logic [2:0]         bit_reg, bit_next;
    logic [2:0]         last_bit_reg, last_bit_next;
    logic               stop_reg, stop_next;
    logic               two_stop_reg, two_stop_next;
    logic [7:0]         shift_reg, shift_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]   level_reg, level_next;
    logic               ready_reg, ready_next;
    logic               busy_reg, busy_next;
    logic               txd_reg, txd_next;

    logic [7:0]         mem [FIFO_DEPTH];
    logic               push, pop, baud_done;
    logic [CNT_W-1:0]   eff_last_cnt;
    logic [2:0]         eff_last_bit;

    // Effective config stored as "last index" values so the counters compare directly.
    always_comb begin
        eff_last_cnt = (ctrl_baud_clks == '0) ? '0 : ctrl_baud_clks - CNT_W'(1);
        if (ctrl_bits < 4'd5)
            eff_last_bit = 3'd4;
        else if (ctrl_bits > 4'd8)
            eff_last_bit = 3'd7;
        else
            eff_last_bit = 3'(ctrl_bits - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= tx_data;
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        last_cnt_next = last_cnt_reg;
        bit_next      = bit_reg;
        last_bit_next = last_bit_reg;
        stop_next     = stop_reg;
        two_stop_next = two_stop_reg;
        shift_next    = shift_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        txd_next      = txd_reg;
        pop           = 1'b0;
        push          = tx_valid & ready_reg;
        baud_done     = (cnt_reg == last_cnt_reg);

        case (state_reg)
            IDLE: begin
                txd_next = 1'b1;
                if (level_reg != '0)
                    pop = 1'b1;
            end
            START: begin
                if (baud_done) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    txd_next   = shift_reg[0];
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    cnt_next = '0;
                    if (bit_reg == last_bit_reg) begin
                        stop_next  = 1'b0;
                        state_next = STOP;
                        txd_next   = 1'b1;
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        shift_next = {1'b0, shift_reg[7:1]};
                        txd_next   = shift_reg[1];
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    cnt_next = '0;
                    if (stop_reg == two_stop_reg) begin
                        if (level_reg != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_next = IDLE;
                            txd_next   = 1'b1;
                        end
                    end else begin
                        stop_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
            end
        endcase

        // A pop loads the next frame and its timing, from IDLE or straight out of STOP.
        if (pop) begin
            state_next    = START;
            cnt_next      = '0;
            shift_next    = mem[rd_ptr_reg];
            last_cnt_next = eff_last_cnt;
            last_bit_next = eff_last_bit;
            two_stop_next = ctrl_stops[1];
            rd_ptr_next   = rd_ptr_reg + PTR_W'(1);
            txd_next      = 1'b0;
        end

        if (push)
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);

        case ({push, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase

        ready_next = (level_next != LVL_W'(FIFO_DEPTH));
        busy_next  = (state_next != IDLE) || (level_next != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            last_cnt_reg <= '0;
            bit_reg      <= '0;
            last_bit_reg <= '0;
            stop_reg     <= 1'b0;
            two_stop_reg <= 1'b0;
            shift_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            ready_reg    <= 1'b1;
            busy_reg     <= 1'b0;
            txd_reg      <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            last_cnt_reg <= last_cnt_next;
            bit_reg      <= bit_next;
            last_bit_reg <= last_bit_next;
            stop_reg     <= stop_next;
            two_stop_reg <= two_stop_next;
            shift_reg    <= shift_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            ready_reg    <= ready_next;
            busy_reg     <= busy_next;
            txd_reg      <= txd_next;
        end
    end

    assign tx_ready   = ready_reg;
    assign txd        = txd_reg;
    assign busy       = busy_reg;
    assign fifo_level = level_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with a simple mid-bit-sampling receive model.
`timescale 1ns/1ps
module tb_uart_tx_serializer;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ctrl_baud_clks;
    logic [3:0]  ctrl_bits;
    logic [1:0]  ctrl_stops;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        txd;
    logic        busy;
    logic [2:0]  fifo_level;

    int check_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    int rst_events = 0;

    int rx_b = 2;
    int rx_d = 8;
    int rx_s = 1;
    logic [7:0] rx_q[$];
    bit         rx_err_q[$];
    int         rx_start_q[$];

    uart_tx_serializer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .ctrl_baud_clks(ctrl_baud_clks), .ctrl_bits(ctrl_bits), .ctrl_stops(ctrl_stops),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .txd(txd), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge rst) rst_events <= rst_events + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Receive model: start detected on the first low cycle, every bit sampled mid-period.
    task automatic rx_frame();
        int b, d, s, r0;
        logic [7:0] v;
        bit ok;
        b = rx_b; d = rx_d; s = rx_s; r0 = rst_events; v = '0; ok = 1'b1;
        rx_start_q.push_back(cyc);
        repeat (b / 2) @(negedge clk);
        if (txd !== 1'b0) ok = 1'b0;
        for (int j = 0; j < d; j++) begin
            repeat (b) @(negedge clk);
            v[j] = txd;
        end
        for (int j = 0; j < s; j++) begin
            repeat (b) @(negedge clk);
            if (txd !== 1'b1) ok = 1'b0;
        end
        if (rst_events == r0 && !rst) begin
            rx_q.push_back(v);
            rx_err_q.push_back(!ok);
        end
    endtask

    initial begin : rx_model
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && txd === 1'b0)
                rx_frame();
        end
    end

    task automatic push(input logic [7:0] d);
        logic acc;
        logic seen;
        int n;
        tx_data = d; tx_valid = 1'b1; seen = 1'b0; n = 0;
        while (!seen && n < 200) begin
            acc = tx_ready;
            @(posedge clk); #1;
            seen = acc;
            n++;
        end
        tx_valid = 1'b0;
        $display("push 0x%02h accepted after %0d cycle(s)", d, n);
        check("push_accept", seen, 1);
    endtask

    task automatic capture(input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[62:0], txd};
            if (i < n - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp);
        int n;
        logic [7:0] v;
        bit e;
        n = 0;
        while (rx_q.size() == 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_got"}, rx_q.size() != 0, 1);
        if (rx_q.size() != 0) begin
            v = rx_q.pop_front();
            e = rx_err_q.pop_front();
            $display("rx %s: byte 0x%02h err %0d", tag, v, e);
            check({tag, "_data"}, v, exp);
            check({tag, "_err"}, e, 0);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, busy, 0);
    endtask

    task automatic set_cfg(input int b, input int d, input int s);
        ctrl_baud_clks = 16'(b); ctrl_bits = 4'(d); ctrl_stops = 2'(s);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [63:0] cap;
        int lows;
        rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
        set_cfg(2, 8, 1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", tx_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: 0xA5, B=2 D=8 S=1
        rx_b = 2; rx_d = 8; rx_s = 1;
        push(8'hA5);
        check("t1_level", fifo_level, 1);
        @(posedge clk); #1;
        capture(20, cap);
        check("t1_frame", cap, 64'b00110011000011001111);
        check("t1_busy_last", busy, 1);
        @(posedge clk); #1;
        check("t1_busy_end", busy, 0);
        check("t1_txd_idle", txd, 1);
        expect_rx("t1", 8'hA5);

        // Test 2: six bytes at B=4 through a depth-4 FIFO
        set_cfg(4, 8, 1); rx_b = 4;
        repeat (3) @(posedge clk);
        #1;
        rx_start_q.delete();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        check("t2_full_level", fifo_level, 4);
        check("t2_full_ready", tx_ready, 0);
        push(8'h66);
        check("t2_refill_level", fifo_level, 4);
        expect_rx("t2_b0", 8'h11);
        expect_rx("t2_b1", 8'h22);
        expect_rx("t2_b2", 8'h33);
        expect_rx("t2_b3", 8'h44);
        expect_rx("t2_b4", 8'h55);
        expect_rx("t2_b5", 8'h66);
        check("t2_starts", rx_start_q.size(), 6);
        if (rx_start_q.size() >= 6)
            for (int k = 0; k < 5; k++)
                check("t2_gap", rx_start_q[k+1] - rx_start_q[k], 40);
        wait_idle("t2_idle");

        // Test 3: D=5 S=2 B=1, 0xFF
        set_cfg(1, 5, 2); rx_b = 1; rx_d = 5; rx_s = 2;
        @(posedge clk); #1;
        push(8'hFF);
        @(posedge clk); #1;
        capture(8, cap);
        check("t3_frame", cap, 64'b01111111);
        @(posedge clk); #1;
        check("t3_busy_end", busy, 0);
        expect_rx("t3", 8'h1F);

        // Test 4: out-of-range controls clamp to D=5 S=1 B=1; upper data bits dropped
        set_cfg(0, 3, 0); rx_b = 1; rx_d = 5; rx_s = 1;
        @(posedge clk); #1;
        push(8'hF5);
        @(posedge clk); #1;
        capture(7, cap);
        check("t4_frame", cap, 64'b0101011);
        @(posedge clk); #1;
        check("t4_busy_end", busy, 0);
        check("t4_txd_idle", txd, 1);
        expect_rx("t4", 8'h15);

        // Test 5: asynchronous reset during data bit 3 of 0x0F with another byte queued
        set_cfg(2, 8, 1); rx_b = 2; rx_d = 8; rx_s = 1;
        @(posedge clk); #1;
        push(8'h0F);
        push(8'hAA);
        check("t5_level_pre", fifo_level, 1);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t5_rst_txd", txd, 1);
        check("t5_rst_level", fifo_level, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ready", tx_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        check("t5_no_frame", lows, 0);
        check("t5_level_after", fifo_level, 0);
        check("t5_no_rx", rx_q.size(), 0);

        // Test 6: baud change mid-frame only affects the next queued byte
        set_cfg(2, 8, 1); rx_b = 2;
        @(posedge clk); #1;
        rx_start_q.delete();
        push(8'h3C);
        push(8'hC3);
        @(posedge clk); #1;
        ctrl_baud_clks = 16'd8; rx_b = 8;
        expect_rx("t6_b0", 8'h3C);
        expect_rx("t6_b1", 8'hC3);
        check("t6_starts", rx_start_q.size(), 2);
        if (rx_start_q.size() >= 2)
            check("t6_first_len", rx_start_q[1] - rx_start_q[0], 20);
        wait_idle("t6_idle");

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
